// File: rtl/ofm_pkg.sv
// Shared OFM store geometry and the read-engine state encoding.
package ofm_pkg;

  localparam int OFM_ROWS   = 44;
  localparam int OFM_COLS   = 4;
  localparam int OFM_DEPTH  = OFM_ROWS * OFM_COLS;
  localparam int OFM_DATA_W = 8;
  localparam int OFM_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ofm_state_e;

endpackage

// File: rtl/ofm_skid_fifo.sv
// Two-entry FIFO with push/pop/count, shared by the stream-side blocks.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module ofm_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only; occupancy is tracked by the reset control above.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/ofm_reader.sv
// OFM read engine: walks a wrapping address range and streams bytes over valid/ready.
// Optional OFM_RELU_EN zeroes negative bytes at the output.
module ofm_reader
  import ofm_pkg::*;
#(
  parameter int DATA_W = OFM_DATA_W,
  parameter int ADDR_W = OFM_ADDR_W,
  parameter int DEPTH  = OFM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ofm_state_e        r_state;
  ofm_state_e        w_next;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W:0]   r_delivered;
  logic              r_inflight;

  logic [ADDR_W:0]   w_len_clamped;
  logic [ADDR_W:0]   w_delivered_nx;
  logic [1:0]        w_fifo_count;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_head_out;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_can_issue;

  assign w_len_clamped  = (length > DEPTH_LEN) ? DEPTH_LEN : length;
  assign out_valid      = !w_fifo_empty;
  assign w_pop          = out_valid && out_ready;
  assign w_delivered_nx = r_delivered + (ADDR_W+1)'(w_pop);

  // Occupancy after this cycle's pop, so a slot freed now can be refilled now.
  assign w_occ       = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_can_issue = (r_issued != r_len) && (w_occ < 3'd2);

  always_comb begin
    w_next   = r_state;
    mem_rden = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (w_len_clamped != '0) ? READ : DONE;
      end
      READ: begin
        busy     = 1'b1;
        mem_rden = w_can_issue;
        if (r_issued == r_len) w_next = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (w_delivered_nx == r_len) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rd_addr   <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= mem_rden;
      if (r_state == IDLE && start) begin
        r_rd_addr   <= base_addr;
        r_len       <= w_len_clamped;
        r_issued    <= '0;
        r_delivered <= '0;
      end else begin
        if (mem_rden) begin
          r_issued  <= r_issued + CNT_ONE;
          r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_W'(1);
        end
        if (w_pop) r_delivered <= w_delivered_nx;
      end
    end
  end

  assign mem_addr = mem_rden ? r_rd_addr : '0;

  ofm_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (r_inflight),
    .i_data  (mem_rdata),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

`ifdef OFM_RELU_EN
  assign w_head_out = w_head[DATA_W-1] ? '0 : w_head;
`else
  assign w_head_out = w_head;
`endif

  assign out_data = out_valid ? w_head_out : '0;
  assign out_last = out_valid && (r_delivered == (r_len - CNT_ONE));

endmodule

// File: tb/tb_ofm_reader.sv
// Bench for ofm_reader: memory model, expected-stream queue and per-cycle output checker.
module tb_ofm_reader;
  import ofm_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 176;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length    = '0;
  logic          busy;
  logic          done;
  logic          mem_rden;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;

  logic [DW-1:0] mem [0:255];

  int cyc       = 0;
  int errors    = 0;
  int checks    = 0;
  int rdy_mode  = 0;
  int rd_cnt    = 0;
  int hs_cnt    = 0;
  int done_cnt  = 0;
  int done_cyc  = -1;
  int exp_rd    = 0;

  logic [DW-1:0] exp_q[$];
  bit            exp_last[$];
  int            hs_cyc_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always #5 clk = ~clk;

  ofm_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_rden  (mem_rden),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always @(posedge clk) begin
    if (mem_rden) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 0) || (cyc % 3 == 0);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [DW-1:0] model_val(input int a);
    logic [DW-1:0] v;
    v = mem[a];
`ifdef OFM_RELU_EN
    if (v[DW-1]) v = '0;
`endif
    return v;
  endfunction

  task automatic push_model(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_val((b + k) % DEPTH));
      exp_last.push_back(k == n - 1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_rd     = exp_q.size();
      rd_cnt     = hs_cnt;
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_rd >= exp_q.size()) fail_now("extra_element");
        else begin
          check("out_data", int'(out_data), int'(exp_q[exp_rd]));
          check("out_last", int'(out_last), int'(exp_last[exp_rd]));
        end
        if (prev_stall) check("stall_stable", int'(out_data), int'(prev_data));
        if (out_ready) begin
          exp_rd++;
          hs_cnt++;
          hs_cyc_q.push_back(cyc);
        end
      end else begin
        if (prev_stall) fail_now("valid_dropped");
        check("last_without_valid", int'(out_last), 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (mem_rden) begin
        rd_cnt++;
        check("outstanding_le2", int'(rd_cnt - hs_cnt <= 2), 1);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_done"},      int'(done), 0);
    check({tag, "_mem_rden"},  int'(mem_rden), 0);
    check({tag, "_mem_addr"},  int'(mem_addr), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"},  int'(out_last), 0);
    check({tag, "_out_data"},  int'(out_data), 0);
  endtask

  task automatic run_xfer(input int b, input int len, input int mode, input int n_lit,
                          output int s);
    int n, hs0, hq0, d0, r0, c0;
    bit got;
    n = (len > DEPTH) ? DEPTH : len;
    check("len_clamp", n, n_lit);
    rdy_mode = mode;
    s = exp_q.size();
    push_model(b, n);
    hs0 = hs_cnt; hq0 = hs_cyc_q.size(); d0 = done_cnt; r0 = rd_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); length = (AW+1)'(len);
    c0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 8'h55; length = 9'd3;
    @(negedge clk);
    check("first_busy",     int'(busy), int'(n != 0));
    check("first_done",     int'(done), int'(n == 0));
    check("first_mem_rden", int'(mem_rden), int'(n != 0));
    check("first_mem_addr", int'(mem_addr), (n != 0) ? b : 0);
    if (n != 0) begin
      @(posedge clk); #1;
      start = 1'b1; base_addr = 8'h33; length = 9'd1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!got) fail_now("done_timeout");
    repeat (3) @(posedge clk);
    check("done_pulses",   done_cnt - d0, 1);
    check("handshakes",    hs_cnt - hs0, n);
    check("reads_issued",  rd_cnt - r0, n);
    check("model_drained", exp_rd, exp_q.size());
    if (mode == 0) begin
      if (n == 0) check("done_cycle_len0", done_cyc, c0);
      else if (hs_cyc_q.size() >= hq0 + n) begin
        check("first_hs_cycle", hs_cyc_q[hq0], c0 + 2);
        check("last_hs_cycle",  hs_cyc_q[hq0 + n - 1], c0 + n + 1);
        check("done_cycle",     done_cyc, c0 + n + 2);
      end
    end
  endtask

  initial begin
    int s, hs0;
    bit got;
    for (int a = 0; a < 256; a++) mem[a] = DW'(a);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    run_xfer(0, 4, 0, 4, s);
    check("model_seq_0", int'(exp_q[s]), 0);
    check("model_seq_3", int'(exp_q[s + 3]), 3);

    run_xfer(174, 4, 0, 4, s);
    check("model_wrap_0", int'(exp_q[s]), 8'hAE);
    check("model_wrap_1", int'(exp_q[s + 1]), 8'hAF);
    check("model_wrap_2", int'(exp_q[s + 2]), 8'h00);
    check("model_wrap_3", int'(exp_q[s + 3]), 8'h01);

    run_xfer(10, 6, 1, 6, s);
    check("model_bp_5", int'(exp_q[s + 5]), 15);

    run_xfer(0, 0, 0, 0, s);

    run_xfer(0, 200, 0, 176, s);
    check("model_full_175", int'(exp_q[s + 175]), 175);

    // Abort a 20-element transfer after its third handshake.
    rdy_mode = 0;
    push_model(0, 20);
    hs0 = hs_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; length = 9'd20;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (hs_cnt - hs0 >= 3) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("mid_reset_timeout");
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy",  int'(busy), 0);
    check("post_rst_valid", int'(out_valid), 0);

    run_xfer(0, 2, 0, 2, s);

    mem[5] = 8'h80;
    mem[6] = 8'h7F;
    run_xfer(5, 2, 0, 2, s);
`ifdef OFM_RELU_EN
    check("model_relu_neg", int'(exp_q[s]), 8'h00);
`else
    check("model_raw_neg", int'(exp_q[s]), 8'h80);
`endif
    check("model_pos", int'(exp_q[s + 1]), 8'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
